// File: rtl/cam_capture_ctrl.sv
// OV7670 capture front-end. It pairs sensor bytes into 16-bit pixels,
// decimates by powers of two and issues framebuffer writes. Capture starts
// and stops only at frame boundaries, and line addresses are accumulated
// rather than multiplied.
module cam_capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_DEC    = 2,
    parameter int V_DEC    = 1,
    parameter int ADDR_W   = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              MODE,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic [7:0]        DATA_IN,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [15:0]       WDATA,
    output logic              FRAME_START,
    output logic              FRAME_DONE,
    output logic [7:0]        FRAME_CNT,
    output logic              FRAME_ERR,
    output logic              BUSY
);

    // x counts up to H_ACTIVE inclusive, and y counts up to V_ACTIVE
    // inclusive. Each counter saturates at that value, which marks overflow.
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);

    localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE);
    // A mask of low bits that must be zero for a kept pixel or line.
    // When the decimation factor is 0, the mask is empty and always passes.
    localparam logic [XW-1:0]     X_MASK    = XW'((1 << H_DEC) - 1);
    localparam logic [YW-1:0]     Y_MASK    = YW'((1 << V_DEC) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> H_DEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic              vs_q, href_q;
    logic              vs_rise, vs_fall, href_fall;
    logic              start_evt, done_evt;
    logic              mode_q;
    logic              phase;
    logic [7:0]        hi;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [YW-1:0]     y_inc, y_after;
    logic [ADDR_W-1:0] line_base;
    logic              pix_done, x_ok, y_ok, wr_ok;
    logic              line_end, line_stored, err_evt;

    assign vs_rise   =  VSYNC & ~vs_q;
    assign vs_fall   = ~VSYNC &  vs_q;
    assign href_fall = ~HREF  &  href_q;
    assign BUSY      = (state != IDLE);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, whatever the statement order.
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and the frame start/done events.
    always_comb begin
        // NOTE: every output gets its default first. Then no path leaves a
        // value unassigned, and no latch is inferred.
        state_nx  = state;
        start_evt = 1'b0;
        done_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (ENABLE) state_nx = ARMED;
            end
            ARMED: begin
                if (!ENABLE) begin
                    state_nx = IDLE;
                end else if (vs_fall) begin
                    state_nx  = ACTIVE;
                    start_evt = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    done_evt = 1'b1;
                    state_nx = ENABLE ? ARMED : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pixel completion, write qualification, line-end and error detection.
    always_comb begin
        pix_done    = (state == ACTIVE) && HREF && phase;
        x_ok        = (x < X_MAX);
        y_ok        = (y < Y_MAX);
        wr_ok       = pix_done && x_ok && y_ok &&
                      ((x & X_MASK) == '0) && ((y & Y_MASK) == '0);
        line_end    = (state == ACTIVE) && href_fall;
        line_stored = y_ok && ((y & Y_MASK) == '0);
        y_inc       = y_ok ? y + YW'(1) : y;
        // The done check sees y after a coincident line end.
        y_after     = line_end ? y_inc : y;
        err_evt     = (pix_done && !x_ok) ||
                      (line_end && y_ok && ((x != X_MAX) || phase)) ||
                      (line_end && !y_ok) ||
                      (done_evt && (y_after != Y_MAX));
    end

    // Edge-detect copies of the sync inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vs_q   <= 1'b0;
            href_q <= 1'b0;
        end else begin
            vs_q   <= VSYNC;
            href_q <= HREF;
        end
    end

    // Byte pairing plus x/y and line-base tracking within a captured frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q    <= 1'b0;
            phase     <= 1'b0;
            hi        <= '0;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
        end else if (start_evt) begin
            mode_q    <= MODE;
            phase     <= 1'b0;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
        end else if (state == ACTIVE) begin
            if (line_end) begin
                x     <= '0;
                phase <= 1'b0;
                y     <= y_inc;
                if (line_stored) line_base <= line_base + LINE_STEP;
            end else if (HREF) begin
                phase <= ~phase;
                if (!phase)    hi <= DATA_IN;
                else if (x_ok) x  <= x + XW'(1);
            end else begin
                phase <= 1'b0;
            end
        end
    end

    // Registered write port and frame status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WE          <= 1'b0;
            WADDR       <= '0;
            WDATA       <= '0;
            FRAME_START <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_CNT   <= '0;
            FRAME_ERR   <= 1'b0;
        end else begin
            WE          <= wr_ok;
            FRAME_START <= start_evt;
            FRAME_DONE  <= done_evt;
            if (wr_ok) begin
                WADDR <= line_base + ADDR_W'(x >> H_DEC);
                WDATA <= mode_q ? {hi[7:3], hi[7:2], hi[7:3]} : {hi, DATA_IN};
            end
            if (done_evt)       FRAME_CNT <= FRAME_CNT + 8'd1;
            if (start_evt)      FRAME_ERR <= 1'b0;
            else if (err_evt)   FRAME_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: an 8x4 sensor with 2x2 decimation.
module tb_cam_capture_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HD = 1;
    localparam int VD = 1;
    localparam int AW = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic          MODE;
    logic          HREF;
    logic          VSYNC;
    logic [7:0]    DATA_IN;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic [15:0]   WDATA;
    logic          FRAME_START;
    logic          FRAME_DONE;
    logic [7:0]    FRAME_CNT;
    logic          FRAME_ERR;
    logic          BUSY;

    int total = 0;
    int bad   = 0;

    // Write log and pulse counters, filled by the monitor below.
    logic [AW-1:0] wa_q[$];
    logic [15:0]   wd_q[$];
    int            n_start = 0;
    int            n_done  = 0;

    // Luma bytes for the grey-mode line: pixel p carries Y = ytab[p].
    logic [7:0] ytab [8] = '{8'hFF, 8'h11, 8'h80, 8'h22, 8'h00, 8'h33, 8'h08, 8'h44};

    cam_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_DEC(HD), .V_DEC(VD), .ADDR_W(AW)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .MODE(MODE), .HREF(HREF),
        .VSYNC(VSYNC), .DATA_IN(DATA_IN), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .FRAME_START(FRAME_START), .FRAME_DONE(FRAME_DONE),
        .FRAME_CNT(FRAME_CNT), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Sample outputs on the falling edge and log writes and pulses.
    always @(negedge CLK) begin
        if (WE) begin
            wa_q.push_back(WADDR);
            wd_q.push_back(WDATA);
        end
        if (FRAME_START) n_start <= n_start + 1;
        if (FRAME_DONE)  n_done  <= n_done + 1;
    end

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge CLK);
        VSYNC   = vs;
        HREF    = hr;
        DATA_IN = d;
    endtask

    task automatic send_line(input int npix, input bit grey);
        for (int j = 0; j < 2 * npix; j++) begin
            if (grey) cyc(1'b0, 1'b1, (j % 2 == 0) ? ytab[(j / 2) % 8] : 8'h5A);
            else      cyc(1'b0, 1'b1, 8'(j));
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_begin();
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        RST = 1'b1; ENABLE = 1'b0; MODE = 1'b0; HREF = 1'b0; VSYNC = 1'b0; DATA_IN = 8'h00;
        repeat (3) @(negedge CLK);
        total++; if (WE !== 1'b0)          begin bad++; $display("FAIL reset_we: got %0h want 0", WE); end
        total++; if (WADDR !== '0)         begin bad++; $display("FAIL reset_waddr: got %0h want 0", WADDR); end
        total++; if (WDATA !== 16'h0)      begin bad++; $display("FAIL reset_wdata: got %0h want 0", WDATA); end
        total++; if (FRAME_START !== 1'b0) begin bad++; $display("FAIL reset_start: got %0h want 0", FRAME_START); end
        total++; if (FRAME_DONE !== 1'b0)  begin bad++; $display("FAIL reset_done: got %0h want 0", FRAME_DONE); end
        total++; if (FRAME_CNT !== 8'h0)   begin bad++; $display("FAIL reset_cnt: got %0h want 0", FRAME_CNT); end
        total++; if (FRAME_ERR !== 1'b0)   begin bad++; $display("FAIL reset_err: got %0h want 0", FRAME_ERR); end
        total++; if (BUSY !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %0h want 0", BUSY); end
        RST = 1'b0;
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        total++; if (BUSY !== 1'b0)        begin bad++; $display("FAIL idle_busy: got %0h want 0", BUSY); end
    endtask

    task automatic test_rgb_frame();
        int w0, s0, d0;
        logic [15:0] exp_d;
        w0 = wa_q.size(); s0 = n_start; d0 = n_done;
        ENABLE = 1'b1; MODE = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL armed_busy: got %0h want 1", BUSY); end
        frame_begin();
        repeat (4) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 8) begin bad++; $display("FAIL rgb_nwrites: got %0d want 8", wa_q.size() - w0); end
        for (int k = 0; k < 8; k++) begin
            exp_d = {8'(4 * (k % 4)), 8'(4 * (k % 4) + 1)};
            total++; if (wa_q[w0 + k] !== AW'(k)) begin bad++; $display("FAIL rgb_addr%0d: got %0h want %0h", k, wa_q[w0 + k], k); end
            total++; if (wd_q[w0 + k] !== exp_d)  begin bad++; $display("FAIL rgb_data%0d: got %0h want %0h", k, wd_q[w0 + k], exp_d); end
        end
        total++; if (n_start - s0 != 1)  begin bad++; $display("FAIL rgb_starts: got %0d want 1", n_start - s0); end
        total++; if (n_done - d0 != 1)   begin bad++; $display("FAIL rgb_dones: got %0d want 1", n_done - d0); end
        total++; if (FRAME_CNT !== 8'd1) begin bad++; $display("FAIL rgb_cnt: got %0d want 1", FRAME_CNT); end
        total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL rgb_err: got %0h want 0", FRAME_ERR); end
        total++; if (BUSY !== 1'b1)      begin bad++; $display("FAIL rgb_rearm: got %0h want 1", BUSY); end
    endtask

    task automatic test_disable_mid_frame();
        int w0, d0;
        w0 = wa_q.size(); d0 = n_done;
        frame_begin();
        repeat (2) send_line(H, 1'b0);
        ENABLE = 1'b0;
        repeat (2) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 8) begin bad++; $display("FAIL dis_nwrites: got %0d want 8", wa_q.size() - w0); end
        total++; if (n_done - d0 != 1)      begin bad++; $display("FAIL dis_dones: got %0d want 1", n_done - d0); end
        total++; if (FRAME_CNT !== 8'd2)    begin bad++; $display("FAIL dis_cnt: got %0d want 2", FRAME_CNT); end
        total++; if (BUSY !== 1'b0)         begin bad++; $display("FAIL dis_busy: got %0h want 0", BUSY); end
        w0 = wa_q.size();
        frame_begin();
        repeat (4) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 0) begin bad++; $display("FAIL dis_idle_writes: got %0d want 0", wa_q.size() - w0); end
        total++; if (FRAME_CNT !== 8'd2)    begin bad++; $display("FAIL dis_idle_cnt: got %0d want 2", FRAME_CNT); end
    endtask

    task automatic test_enable_mid_frame_grey();
        int w0, s0;
        logic [15:0] exp_g [4];
        exp_g = '{16'hFFFF, 16'h8410, 16'h0000, 16'h0841};
        w0 = wa_q.size(); s0 = n_start;
        frame_begin();
        send_line(H, 1'b0);
        ENABLE = 1'b1; MODE = 1'b1;
        repeat (3) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 0) begin bad++; $display("FAIL en_early_writes: got %0d want 0", wa_q.size() - w0); end
        total++; if (n_start - s0 != 0)     begin bad++; $display("FAIL en_early_start: got %0d want 0", n_start - s0); end
        total++; if (BUSY !== 1'b1)         begin bad++; $display("FAIL en_armed_busy: got %0h want 1", BUSY); end
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge CLK);
        total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL en_start_pulse: got %0h want 1", FRAME_START); end
        cyc(1'b0, 1'b0, 8'h00);
        total++; if (FRAME_START !== 1'b0) begin bad++; $display("FAIL en_start_width: got %0h want 0", FRAME_START); end
        repeat (4) send_line(H, 1'b1);
        frame_end();
        total++; if (wa_q.size() - w0 != 8) begin bad++; $display("FAIL grey_nwrites: got %0d want 8", wa_q.size() - w0); end
        for (int k = 0; k < 4; k++) begin
            total++; if (wa_q[w0 + k] !== AW'(k))  begin bad++; $display("FAIL grey_addr%0d: got %0h want %0h", k, wa_q[w0 + k], k); end
            total++; if (wd_q[w0 + k] !== exp_g[k]) begin bad++; $display("FAIL grey_data%0d: got %0h want %0h", k, wd_q[w0 + k], exp_g[k]); end
        end
        total++; if (FRAME_CNT !== 8'd3) begin bad++; $display("FAIL grey_cnt: got %0d want 3", FRAME_CNT); end
        total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL grey_err: got %0h want 0", FRAME_ERR); end
        MODE = 1'b0;
    endtask

    task automatic test_bad_lines();
        int w0;
        w0 = wa_q.size();
        frame_begin();
        send_line(H + 1, 1'b0);
        total++; if (FRAME_ERR !== 1'b1) begin bad++; $display("FAIL long_line_err: got %0h want 1", FRAME_ERR); end
        send_line(H - 1, 1'b0);
        repeat (2) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 8) begin bad++; $display("FAIL bad_nwrites: got %0d want 8", wa_q.size() - w0); end
        total++; if (wa_q[w0 + 3] !== AW'(3)) begin bad++; $display("FAIL bad_last_addr0: got %0h want 3", wa_q[w0 + 3]); end
        total++; if (wa_q[w0 + 4] !== AW'(4)) begin bad++; $display("FAIL bad_line2_base: got %0h want 4", wa_q[w0 + 4]); end
        total++; if (FRAME_ERR !== 1'b1)      begin bad++; $display("FAIL bad_err_sticky: got %0h want 1", FRAME_ERR); end
        total++; if (FRAME_CNT !== 8'd4)      begin bad++; $display("FAIL bad_cnt: got %0d want 4", FRAME_CNT); end
        frame_begin();
        total++; if (FRAME_ERR !== 1'b0)      begin bad++; $display("FAIL err_cleared: got %0h want 0", FRAME_ERR); end
    endtask

    // Continues the frame that test_bad_lines has just started.
    task automatic test_reset_mid_frame();
        int w0;
        send_line(H, 1'b0);
        for (int j = 0; j < 6; j++) cyc(1'b0, 1'b1, 8'(j));
        #1 RST = 1'b1;
        #1;
        total++; if (WE !== 1'b0)        begin bad++; $display("FAIL rst_mid_we: got %0h want 0", WE); end
        total++; if (WADDR !== '0)       begin bad++; $display("FAIL rst_mid_waddr: got %0h want 0", WADDR); end
        total++; if (WDATA !== 16'h0)    begin bad++; $display("FAIL rst_mid_wdata: got %0h want 0", WDATA); end
        total++; if (FRAME_CNT !== 8'h0) begin bad++; $display("FAIL rst_mid_cnt: got %0h want 0", FRAME_CNT); end
        total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy: got %0h want 0", BUSY); end
        for (int j = 6; j < 10; j++) cyc(1'b0, 1'b1, 8'(j));
        RST = 1'b0;
        w0 = wa_q.size();
        for (int j = 10; j < 16; j++) cyc(1'b0, 1'b1, 8'(j));
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        repeat (2) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 0) begin bad++; $display("FAIL rst_no_partial: got %0d want 0", wa_q.size() - w0); end
        frame_begin();
        repeat (4) send_line(H, 1'b0);
        frame_end();
        total++; if (wa_q.size() - w0 != 8)  begin bad++; $display("FAIL rst_nwrites: got %0d want 8", wa_q.size() - w0); end
        total++; if (wa_q[w0] !== AW'(0))    begin bad++; $display("FAIL rst_first_addr: got %0h want 0", wa_q[w0]); end
        total++; if (wd_q[w0] !== 16'h0001)  begin bad++; $display("FAIL rst_first_data: got %0h want 0001", wd_q[w0]); end
        total++; if (FRAME_CNT !== 8'd1)     begin bad++; $display("FAIL rst_cnt: got %0d want 1", FRAME_CNT); end
        total++; if (FRAME_ERR !== 1'b0)     begin bad++; $display("FAIL rst_err: got %0h want 0", FRAME_ERR); end
    endtask

    initial begin
        test_reset();
        test_rgb_frame();
        test_disable_mid_frame();
        test_enable_mid_frame_grey();
        test_bad_lines();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
